// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM states and
// the encodings of the multi-bit control fields.
package mc_ctrl_pkg;

    localparam int unsigned OPC_NOOP = 0;
    localparam int unsigned OPC_LOD  = 1;
    localparam int unsigned OPC_STR  = 2;
    localparam int unsigned OPC_SWAP = 3;
    localparam int unsigned OPC_BRA  = 4;
    localparam int unsigned OPC_BRR  = 5;
    localparam int unsigned OPC_BNE  = 6;
    localparam int unsigned OPC_ALU  = 8;
    localparam int unsigned OPC_HLT  = 15;

    // Wide enough for the largest allowed TIMEOUT (255)
    localparam int unsigned TMR_W = 8;

    typedef enum logic [3:0] {
        ST_START0,
        ST_START1,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_WB2,
        ST_HALT
    } state_t;

    localparam logic [1:0] ALU_OP_PASS = 2'b00;
    localparam logic [1:0] ALU_OP_IMM  = 2'b01;
    localparam logic [1:0] ALU_OP_SUB  = 2'b10;

    localparam logic [1:0] RD_SEL_RS   = 2'd0;
    localparam logic [1:0] RD_SEL_IMM  = 2'd1;
    localparam logic [1:0] RD_SEL_SWAP = 2'd2;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       rf_we;
        logic       wb_sel;
        logic [1:0] rd_sel;
        logic [1:0] alu_op;
        logic       mm_sel;
        logic       dm_we;
        logic       dm_re;
        logic       swap_sel;
        logic       halted;
    } ctrl_t;

    function automatic logic opc_defined(input int unsigned opc);
        case (opc)
            OPC_NOOP, OPC_LOD, OPC_STR, OPC_SWAP, OPC_BRA,
            OPC_BRR, OPC_BNE, OPC_ALU, OPC_HLT: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive MEM cycles; flags the cycle in which the TIMEOUT-th
// wait cycle is being spent. Clears whenever the FSM is outside MEM.
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expired_c_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    assign expired_c_o = (cnt_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (!expired_c_o) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects from the present state and latched instruction.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned     OP_W     = 4,
    parameter int unsigned     MM_W     = 4,
    parameter int unsigned     CNT_W    = 16,
    parameter int unsigned     TIMEOUT  = 15,
    parameter logic [MM_W-1:0] IMM_MODE = MM_W'(4'b1000)
) (
    input  logic             CLK,
    input  logic             RST_F,
    input  logic [OP_W-1:0]  OPCODE,
    input  logic [MM_W-1:0]  MM,
    input  logic [MM_W-1:0]  STAT,
    input  logic             DM_ACK,
    output logic             PC_RST,
    output logic             PC_WRITE,
    output logic             PC_SEL,
    output logic             BR_SEL,
    output logic             RF_WE,
    output logic             WB_SEL,
    output logic [1:0]       RD_SEL,
    output logic [1:0]       ALU_OP,
    output logic             MM_SEL,
    output logic             DM_WE,
    output logic             DM_RE,
    output logic             SWAP_SEL,
    output logic             HALTED,
    output logic             ERR,
    output logic [CNT_W-1:0] RETIRED
);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic [MM_W-1:0]  mm_q;
    logic             err_q;
    logic [CNT_W-1:0] ret_q;

    ctrl_t ctrl_c;
    logic  err_set_c;
    logic  mem_run_c;
    logic  expired_c;
    logic  retire_c;

    logic is_lod, is_str, is_swap, is_bra, is_brr, is_bne, is_alu, is_hlt;
    logic is_imm, mm_zero, br_hit, br_taken;

    assign is_lod  = (op_q == OP_W'(OPC_LOD));
    assign is_str  = (op_q == OP_W'(OPC_STR));
    assign is_swap = (op_q == OP_W'(OPC_SWAP));
    assign is_bra  = (op_q == OP_W'(OPC_BRA));
    assign is_brr  = (op_q == OP_W'(OPC_BRR));
    assign is_bne  = (op_q == OP_W'(OPC_BNE));
    assign is_alu  = (op_q == OP_W'(OPC_ALU));
    assign is_hlt  = (op_q == OP_W'(OPC_HLT));
    assign is_imm  = (mm_q == IMM_MODE);
    assign mm_zero = (mm_q == '0);
    // STAT is live: branch outcome is decided in the EXECUTE cycle itself
    assign br_hit   = ((mm_q & STAT) != '0);
    assign br_taken = ((is_bra || is_brr) && br_hit) || (is_bne && !br_hit);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk         (CLK),
        .rst_n       (RST_F),
        .run_i       (mem_run_c),
        .expired_c_o (expired_c)
    );

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q <= ST_START0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ctrl_c           = '0;
        ctrl_c.rd_sel    = RD_SEL_RS;
        ctrl_c.alu_op    = ALU_OP_PASS;
        err_set_c        = 1'b0;
        mem_run_c        = 1'b0;

        case (state_q)
            ST_START0: begin
                ctrl_c.pc_rst = 1'b1;
                state_d       = ST_START1;
            end
            ST_START1: begin
                ctrl_c.pc_rst = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl_c.pc_write = 1'b1;
                state_d         = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_lod || (is_alu && is_imm)) begin
                    ctrl_c.rd_sel = RD_SEL_IMM;
                end else if (is_swap) begin
                    ctrl_c.rd_sel = RD_SEL_SWAP;
                end
                if (is_hlt) begin
                    state_d = ST_HALT;
                end else if (!opc_defined(32'(op_q))) begin
                    state_d   = ST_HALT;
                    err_set_c = 1'b1;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if ((is_alu && is_imm) || ((is_lod || is_str) && mm_zero)) begin
                    ctrl_c.alu_op = ALU_OP_IMM;
                end else if (is_bra || is_brr || is_bne || is_swap) begin
                    ctrl_c.alu_op = ALU_OP_SUB;
                end
                ctrl_c.mm_sel = (is_lod || is_str) && is_imm;
                if (br_taken) begin
                    ctrl_c.pc_sel   = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.br_sel   = is_bra || is_bne;
                end
                if (is_alu || is_lod || is_str) begin
                    state_d = ST_MEM;
                end else if (is_swap) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_run_c = 1'b1;
                if (is_alu) begin
                    ctrl_c.rf_we = 1'b1;
                    state_d      = ST_FETCH;
                end else begin
                    ctrl_c.dm_re = is_lod;
                    ctrl_c.dm_we = is_str;
                    // An ACK in the final wait cycle beats the timeout
                    if (DM_ACK) begin
                        state_d = is_lod ? ST_WB : ST_FETCH;
                    end else if (expired_c) begin
                        state_d   = ST_HALT;
                        err_set_c = 1'b1;
                    end
                end
            end
            ST_WB: begin
                ctrl_c.rf_we  = 1'b1;
                ctrl_c.wb_sel = is_lod;
                state_d       = is_swap ? ST_WB2 : ST_FETCH;
            end
            ST_WB2: begin
                ctrl_c.rf_we    = 1'b1;
                ctrl_c.swap_sel = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_HALT: begin
                ctrl_c.halted = 1'b1;
            end
            default: begin
                state_d = ST_START0;
            end
        endcase
    end

    assign retire_c = (state_d == ST_FETCH) &&
                      ((state_q == ST_EXECUTE) || (state_q == ST_MEM) ||
                       (state_q == ST_WB) || (state_q == ST_WB2));

    // Instruction latch, sticky error and saturating retire counter
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            op_q  <= '0;
            mm_q  <= '0;
            err_q <= 1'b0;
            ret_q <= '0;
        end else begin
            if (state_q == ST_FETCH) begin
                op_q <= OPCODE;
                mm_q <= MM;
            end
            if (err_set_c) begin
                err_q <= 1'b1;
            end
            if (retire_c && (ret_q != '1)) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign PC_RST   = ctrl_c.pc_rst;
    assign PC_WRITE = ctrl_c.pc_write;
    assign PC_SEL   = ctrl_c.pc_sel;
    assign BR_SEL   = ctrl_c.br_sel;
    assign RF_WE    = ctrl_c.rf_we;
    assign WB_SEL   = ctrl_c.wb_sel;
    assign RD_SEL   = ctrl_c.rd_sel;
    assign ALU_OP   = ctrl_c.alu_op;
    assign MM_SEL   = ctrl_c.mm_sel;
    assign DM_WE    = ctrl_c.dm_we;
    assign DM_RE    = ctrl_c.dm_re;
    assign SWAP_SEL = ctrl_c.swap_sel;
    assign HALTED   = ctrl_c.halted;
    assign ERR      = err_q;
    assign RETIRED  = ret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table, hand-written corner
// sequences and random instructions against a cycle-list reference model.
module tb_mc_ctrl;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned MM_W    = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          TIMEOUT = 15;
    localparam int          RET_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST_F;
    logic [OP_W-1:0]  OPCODE;
    logic [MM_W-1:0]  MM;
    logic [MM_W-1:0]  STAT;
    logic             DM_ACK;
    logic             PC_RST, PC_WRITE, PC_SEL, BR_SEL, RF_WE, WB_SEL;
    logic [1:0]       RD_SEL, ALU_OP;
    logic             MM_SEL, DM_WE, DM_RE, SWAP_SEL, HALTED, ERR;
    logic [CNT_W-1:0] RETIRED;

    mc_ctrl #(
        .OP_W    (OP_W),
        .MM_W    (MM_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .IMM_MODE(4'b1000)
    ) dut (
        .CLK(CLK), .RST_F(RST_F), .OPCODE(OPCODE), .MM(MM), .STAT(STAT),
        .DM_ACK(DM_ACK), .PC_RST(PC_RST), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL),
        .BR_SEL(BR_SEL), .RF_WE(RF_WE), .WB_SEL(WB_SEL), .RD_SEL(RD_SEL),
        .ALU_OP(ALU_OP), .MM_SEL(MM_SEL), .DM_WE(DM_WE), .DM_RE(DM_RE),
        .SWAP_SEL(SWAP_SEL), .HALTED(HALTED), .ERR(ERR), .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       rf_we;
        logic       wb_sel;
        logic [1:0] rd_sel;
        logic [1:0] alu_op;
        logic       mm_sel;
        logic       dm_we;
        logic       dm_re;
        logic       swap_sel;
        logic       halted;
    } exp_t;

    // kind: 0 = ordinary cycle, 1 = execute (STAT applied), 2 = memory wait
    typedef struct {
        exp_t ctl;
        int   kind;
        bit   ack;
    } cyc_t;

    typedef struct {
        int op, mm, stat, dly;
        int rd, alu, pcs, brs, dmc;
        bit err, hlt;
    } vec_t;

    cyc_t seq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   ret_m = 0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act_v, exp_v);
        end
    endtask

    function automatic exp_t act();
        exp_t a;
        a = {PC_RST, PC_WRITE, PC_SEL, BR_SEL, RF_WE, WB_SEL, RD_SEL, ALU_OP,
             MM_SEL, DM_WE, DM_RE, SWAP_SEL, HALTED};
        return a;
    endfunction

    function automatic exp_t only_rst();
        exp_t e = '0;
        e.pc_rst = 1'b1;
        return e;
    endfunction

    function automatic exp_t only_halt();
        exp_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    task automatic push(input exp_t e, input int kind, input bit ack);
        cyc_t c;
        c.ctl  = e;
        c.kind = kind;
        c.ack  = ack;
        seq.push_back(c);
    endtask

    // Reference model: expected per-cycle control outputs for one instruction
    task automatic build(input int op, input int mm, input int stat, input int dly,
                         output bit halts, output bit err);
        exp_t e;
        bit   lodstr, taken, defined;
        int   nmem;
        seq.delete();
        halts   = 0;
        err     = 0;
        defined = (op <= 6) || (op == 8);
        lodstr  = (op == 1) || (op == 2);
        e = '0; e.pc_write = 1'b1; push(e, 0, 0);
        e = '0;
        if (op == 1 || (op == 8 && mm == 8)) e.rd_sel = 2'd1;
        else if (op == 3)                    e.rd_sel = 2'd2;
        push(e, 0, 0);
        if (!defined) begin
            halts = 1; err = (op != 15);
            push(only_halt(), 0, 0); push(only_halt(), 0, 0);
            return;
        end
        e = '0;
        if ((op == 8 && mm == 8) || (lodstr && mm == 0)) e.alu_op = 2'b01;
        else if (op >= 3 && op <= 6)                     e.alu_op = 2'b10;
        e.mm_sel = lodstr && (mm == 8);
        taken = ((op == 4 || op == 5) && (mm & stat) != 0) || (op == 6 && (mm & stat) == 0);
        if (taken) begin
            e.pc_sel = 1'b1; e.pc_write = 1'b1; e.br_sel = (op != 5);
        end
        push(e, 1, 0);
        if (op == 8) begin
            e = '0; e.rf_we = 1'b1; push(e, 0, 0);
        end
        if (lodstr) begin
            nmem = (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
            e = '0; e.dm_re = (op == 1); e.dm_we = (op == 2);
            for (int i = 0; i < nmem; i++) push(e, 2, i == dly);
            if (dly >= TIMEOUT) begin
                halts = 1; err = 1;
                push(only_halt(), 2, 0); push(only_halt(), 0, 0);
                return;
            end
        end
        if (op == 1) begin
            e = '0; e.rf_we = 1'b1; e.wb_sel = 1'b1; push(e, 0, 0);
        end
        if (op == 3) begin
            e = '0; e.rf_we = 1'b1; push(e, 0, 0);
            e.swap_sel = 1'b1; push(e, 0, 0);
        end
    endtask

    // Called at a negedge; returns at the negedge that starts FETCH
    task automatic do_reset();
        RST_F = 1'b0;
        #1;
        chk("reset ctl", 32'(act()), 32'(only_rst()));
        chk("reset retired", 32'(RETIRED), 32'd0);
        chk("reset err", 32'(ERR), 32'd0);
        @(negedge CLK);
        RST_F = 1'b1;
        #1 chk("start0 ctl", 32'(act()), 32'(only_rst()));
        @(negedge CLK);
        #1 chk("start1 ctl", 32'(act()), 32'(only_rst()));
        @(negedge CLK);
        ret_m = 0;
    endtask

    // Runs one instruction from FETCH, checking every cycle against the model
    task automatic run(input int op, input int mm, input int stat, input int dly,
                       output int rd, output int alu, output int pcs, output int brs,
                       output int dmc, output bit err_a, output bit hlt_a);
        bit halts, err_m;
        build(op, mm, stat, dly, halts, err_m);
        rd = 0; alu = 0; pcs = 0; brs = 0; dmc = 0;
        foreach (seq[i]) begin
            OPCODE = (i == 0) ? OP_W'(op) : OP_W'($urandom);
            MM     = (i == 0) ? MM_W'(mm) : MM_W'($urandom);
            STAT   = (seq[i].kind == 1) ? MM_W'(stat) : MM_W'($urandom);
            DM_ACK = (seq[i].kind == 2) ? seq[i].ack : 1'($urandom);
            #1;
            chk($sformatf("ctl op%0d mm%0d st%0d d%0d cyc%0d", op, mm, stat, dly, i),
                32'(act()), 32'(seq[i].ctl));
            if (i == 1) rd = int'(RD_SEL);
            if (i == 2) begin
                alu = int'(ALU_OP); pcs = int'(PC_SEL); brs = int'(BR_SEL);
            end
            if (DM_RE || DM_WE) dmc++;
            @(negedge CLK);
        end
        #1;
        err_a = ERR;
        hlt_a = HALTED;
        if (halts) begin
            chk($sformatf("err after halt op%0d", op), 32'(ERR), 32'(err_m));
            chk($sformatf("halted op%0d", op), 32'(HALTED), 32'd1);
            do_reset();
        end else begin
            ret_m = (ret_m == RET_MAX) ? RET_MAX : ret_m + 1;
            chk($sformatf("retired op%0d", op), 32'(RETIRED), 32'(ret_m));
            chk($sformatf("err op%0d", op), 32'(ERR), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        int   valid[8];
        int   rd, alu, pcs, brs, dmc, op, mm;
        bit   err_a, hlt_a;

        valid = '{0, 1, 2, 3, 4, 5, 6, 8};
        //           op  mm st  dly  rd alu pcs brs dmc err hlt
        tbl[0]  = '{ 8,  8, 0,  0,   1, 1,  0,  0,  0,  0,  0};
        tbl[1]  = '{ 4,  2, 2,  0,   0, 2,  1,  1,  0,  0,  0};
        tbl[2]  = '{ 4,  2, 0,  0,   0, 2,  0,  0,  0,  0,  0};
        tbl[3]  = '{ 5,  3, 1,  0,   0, 2,  1,  0,  0,  0,  0};
        tbl[4]  = '{ 6,  4, 3,  0,   0, 2,  1,  1,  0,  0,  0};
        tbl[5]  = '{ 6,  4, 4,  0,   0, 2,  0,  0,  0,  0,  0};
        tbl[6]  = '{ 1,  0, 0,  3,   1, 1,  0,  0,  4,  0,  0};
        tbl[7]  = '{ 1,  8, 0,  0,   1, 0,  0,  0,  1,  0,  0};
        tbl[8]  = '{ 2,  0, 0, 14,   0, 1,  0,  0, 15,  0,  0};
        tbl[9]  = '{ 3,  5, 0,  0,   2, 2,  0,  0,  0,  0,  0};
        tbl[10] = '{ 0,  0, 0,  0,   0, 0,  0,  0,  0,  0,  0};
        tbl[11] = '{ 8,  3, 0,  0,   0, 0,  0,  0,  0,  0,  0};
        tbl[12] = '{ 2,  8, 0, 99,   0, 0,  0,  0, 15,  1,  1};
        tbl[13] = '{15,  0, 0,  0,   0, 0,  0,  0,  0,  0,  1};
        tbl[14] = '{ 7,  0, 0,  0,   0, 0,  0,  0,  0,  1,  1};

        RST_F = 1'b0; OPCODE = '0; MM = '0; STAT = '0; DM_ACK = 1'b0;
        @(negedge CLK);
        do_reset();

        foreach (tbl[k]) begin
            run(tbl[k].op, tbl[k].mm, tbl[k].stat, tbl[k].dly,
                rd, alu, pcs, brs, dmc, err_a, hlt_a);
            chk($sformatf("tbl%0d rd_sel", k), 32'(rd), 32'(tbl[k].rd));
            chk($sformatf("tbl%0d alu_op", k), 32'(alu), 32'(tbl[k].alu));
            chk($sformatf("tbl%0d pc_sel", k), 32'(pcs), 32'(tbl[k].pcs));
            chk($sformatf("tbl%0d br_sel", k), 32'(brs), 32'(tbl[k].brs));
            chk($sformatf("tbl%0d dm cycles", k), 32'(dmc), 32'(tbl[k].dmc));
            chk($sformatf("tbl%0d err", k), 32'(err_a), 32'(tbl[k].err));
            chk($sformatf("tbl%0d halted", k), 32'(hlt_a), 32'(tbl[k].hlt));
        end

        // hlt must hold HALT regardless of inputs until reset
        OPCODE = OP_W'(15); MM = '0; DM_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            OPCODE = OP_W'($urandom); MM = MM_W'($urandom);
            STAT = MM_W'($urandom); DM_ACK = 1'($urandom);
            #1 chk($sformatf("hlt hold cyc%0d", c), 32'(act()), 32'(only_halt()));
            @(negedge CLK);
        end
        #1 chk("hlt err", 32'(ERR), 32'd0);
        do_reset();

        // Random instruction mix, including occasional halts and timeouts
        for (int n = 0; n < 150; n++) begin
            int r, stat, dly;
            r = int'($urandom_range(0, 19));
            if (r == 0)      op = 15;
            else if (r == 1) op = ($urandom_range(0, 1) == 0) ? 7 : 9 + int'($urandom_range(0, 5));
            else             op = valid[$urandom_range(0, 7)];
            r = int'($urandom_range(0, 3));
            mm   = (r == 0) ? 8 : (r == 1) ? 0 : int'($urandom_range(0, 15));
            stat = int'($urandom_range(0, 15));
            dly  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18))
                                               : int'($urandom_range(0, 4));
            run(op, mm, stat, dly, rd, alu, pcs, brs, dmc, err_a, hlt_a);
        end

        // RETIRED saturation
        do_reset();
        for (int n = 0; n < RET_MAX + 2; n++) begin
            run(0, 0, 0, 0, rd, alu, pcs, brs, dmc, err_a, hlt_a);
        end
        #1 chk("retired saturated", 32'(RETIRED), 32'(RET_MAX));

        // Asynchronous reset in the middle of a MEM wait
        run(0, 0, 0, 0, rd, alu, pcs, brs, dmc, err_a, hlt_a);
        do_reset();
        run(8, 0, 0, 0, rd, alu, pcs, brs, dmc, err_a, hlt_a);
        OPCODE = OP_W'(1); MM = '0; DM_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        #1 chk("midmem dm_re", 32'(DM_RE), 32'd1);
        chk("midmem retired before", 32'(RETIRED), 32'd1);
        #2 RST_F = 1'b0;
        #1;
        chk("midmem async ctl", 32'(act()), 32'(only_rst()));
        chk("midmem async retired", 32'(RETIRED), 32'd0);
        chk("midmem async err", 32'(ERR), 32'd0);
        @(negedge CLK);
        do_reset();
        run(3, 0, 0, 0, rd, alu, pcs, brs, dmc, err_a, hlt_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
